// File: rtl/sseg_scan_controller.sv
// Time-multiplexed driver for a four-digit seven-segment display.
// Scans one digit per slot with a blanking guard, double-buffered value and leading-zero blanking.
module sseg_scan_controller #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Enable,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DPMask,
  input  logic        BlankLeadZero,
  output logic [3:0]  Hex,
  output logic        DP,
  output logic [3:0]  AN,
  output logic        FrameTick,
  output logic        Busy
);

  localparam int               DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit;
  logic [15:0]      r_act_val;
  logic [3:0]       r_act_dp;
  logic [15:0]      r_pend_val;
  logic [3:0]       r_pend_dp;
  logic             r_busy;
  logic [3:0]       r_hex;
  logic             r_dp;
  logic [3:0]       r_an;
  logic             r_frame_tick;

  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_direct_load;
  logic [3:0]       w_nibble;
  logic [3:0]       w_blank;
  logic [3:0]       w_an_next;

  assign w_slot_end    = Enable && (r_div_cnt == DIV_LAST);
  assign w_frame_end   = w_slot_end && (r_digit == 2'd3);
  // A load lands straight in the active registers whenever nothing is being scanned out
  // mid-frame: either the scan is stopped or this is the frame-boundary cycle.
  assign w_direct_load = !Enable || w_frame_end;
  assign w_nibble      = r_act_val[{r_digit, 2'b00} +: 4];

  // Scan position: slot counter and digit index.
  always_ff @(posedge Clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (Rst) begin
      r_div_cnt <= '0;
      r_digit   <= '0;
    end else if (!Enable) begin
      r_div_cnt <= '0;
      r_digit   <= '0;
    end else if (w_slot_end) begin
      r_div_cnt <= '0;
      r_digit   <= r_digit + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Pending/active double buffer; the active copy only changes on a frame boundary
  // while scanning, so a frame never mixes two values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_act_val  <= '0;
      r_act_dp   <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_busy     <= 1'b0;
    end else if (Load) begin
      r_pend_val <= Value;
      r_pend_dp  <= DPMask;
      if (w_direct_load) begin
        r_act_val <= Value;
        r_act_dp  <= DPMask;
        r_busy    <= 1'b0;
      end else begin
        r_busy    <= 1'b1;
      end
    end else if (r_busy && w_direct_load) begin
      r_act_val <= r_pend_val;
      r_act_dp  <= r_pend_dp;
      r_busy    <= 1'b0;
    end
  end

  // Digit i is blanked when it and every digit to its left hold zero; digit 0 never is.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_blank    = 4'b0000;
    w_blank[3] = BlankLeadZero && (r_act_val[15:12] == 4'h0);
    w_blank[2] = w_blank[3] && (r_act_val[11:8] == 4'h0);
    w_blank[1] = w_blank[2] && (r_act_val[7:4] == 4'h0);
  end

  always_comb begin
    w_an_next = 4'b1111;
    if (Enable && (r_div_cnt >= BLANK_END) && !w_blank[r_digit]) begin
      w_an_next = ~(4'b0001 << r_digit);
    end
  end

  // Output register stage: one cycle behind the scan position.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_hex        <= 4'h0;
      r_dp         <= 1'b0;
      r_an         <= 4'b1111;
      r_frame_tick <= 1'b0;
    end else begin
      r_hex        <= w_nibble;
      r_dp         <= r_act_dp[r_digit];
      r_an         <= w_an_next;
      r_frame_tick <= w_frame_end;
    end
  end

  assign Hex       = r_hex;
  assign DP        = r_dp;
  assign AN        = r_an;
  assign FrameTick = r_frame_tick;
  assign Busy      = r_busy;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Self-checking bench for sseg_scan_controller (REFRESH_DIV=8, BLANK_CYC=2).
// Stimulus queues the expected lit-digit runs; a monitor compares each run as it ends.
module tb_sseg_scan_controller;

  logic        Clk;
  logic        Rst;
  logic        Enable;
  logic        Load;
  logic [15:0] Value;
  logic [3:0]  DPMask;
  logic        BlankLeadZero;
  logic [3:0]  Hex;
  logic        DP;
  logic [3:0]  AN;
  logic        FrameTick;
  logic        Busy;

  sseg_scan_controller #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Enable       (Enable),
    .Load         (Load),
    .Value        (Value),
    .DPMask       (DPMask),
    .BlankLeadZero(BlankLeadZero),
    .Hex          (Hex),
    .DP           (DP),
    .AN           (AN),
    .FrameTick    (FrameTick),
    .Busy         (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One uninterrupted stretch of a digit's anode held low.
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] hex;
    logic       dp;
    logic [7:0] len;
  } run_t;

  run_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic mon_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic push_run(input logic [3:0] an, input logic [3:0] hex, input logic dp, input int len);
    run_t r;
    r.an  = an;
    r.hex = hex;
    r.dp  = dp;
    r.len = 8'(len);
    exp_q.push_back(r);
  endtask

  // Full frame, no blanking: digits 0..3 each lit for 6 of 8 cycles.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm);
    push_run(4'b1110, v[3:0],   dpm[0], 6);
    push_run(4'b1101, v[7:4],   dpm[1], 6);
    push_run(4'b1011, v[11:8],  dpm[2], 6);
    push_run(4'b0111, v[15:12], dpm[3], 6);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dpm);
    Load   = 1'b1;
    Value  = v;
    DPMask = dpm;
    step(1);
    Load   = 1'b0;
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (FrameTick !== 1'b1 && n < 200);
    if (FrameTick !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_tick_timeout: no FrameTick within %0d cycles", n);
    end
  endtask

  // Monitor: emits a run when a lit anode pattern ends, and compares it with the queue head.
  initial begin
    logic [3:0] prev_an;
    logic [3:0] run_hex;
    logic       run_dp;
    int         run_len;
    run_t       got;
    run_t       exp;
    prev_an = 4'b1111;
    run_hex = 4'h0;
    run_dp  = 1'b0;
    run_len = 0;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        if (AN !== prev_an) begin
          if (prev_an !== 4'b1111) begin
            got.an  = prev_an;
            got.hex = run_hex;
            got.dp  = run_dp;
            got.len = 8'(run_len);
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL digit_run: unexpected run an=%b hex=%h dp=%b len=%0d",
                       got.an, got.hex, got.dp, got.len);
            end else begin
              exp = exp_q.pop_front();
              if (got !== exp) begin
                n_fail++;
                $display("FAIL digit_run: got an=%b hex=%h dp=%b len=%0d, expected an=%b hex=%h dp=%b len=%0d",
                         got.an, got.hex, got.dp, got.len, exp.an, exp.hex, exp.dp, exp.len);
              end
            end
          end
          if (AN !== 4'b1111) begin
            run_hex = Hex;
            run_dp  = DP;
            run_len = 1;
          end
        end else if (AN !== 4'b1111) begin
          run_len++;
        end
        prev_an = AN;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    Rst = 1'b1; Enable = 1'b0; Load = 1'b0; Value = '0; DPMask = '0; BlankLeadZero = 1'b0;
    step(3);
    check("rst_an", AN, 4'b1111);
    check("rst_hex", Hex, 4'h0);
    check("rst_dp", DP, 1'b0);
    check("rst_frame_tick", FrameTick, 1'b0);
    check("rst_busy", Busy, 1'b0);
    Rst    = 1'b0;
    mon_en = 1'b1;

    // Load while stopped goes straight to the active registers.
    load(16'h12AF, 4'b0000);
    check("busy_load_disabled", Busy, 1'b0);
    check("an_dark_disabled", AN, 4'b1111);

    // F1..F3 show 12AF; FrameTick every 32 cycles.
    push_frame(16'h12AF, 4'b0000);
    push_frame(16'h12AF, 4'b0000);
    push_frame(16'h12AF, 4'b0000);
    Enable = 1'b1;
    wait_ft(n);
    check("ft_first", n, 32);
    wait_ft(n);
    check("ft_period", n, 32);

    // F3: mid-frame load stays pending until the boundary.
    push_frame(16'h1234, 4'b0000);
    step(10);
    load(16'h1234, 4'b0000);
    check("busy_pending", Busy, 1'b1);
    wait_ft(n);
    check("ft_after_load", n, 21);
    check("busy_clear_boundary", Busy, 1'b0);

    // F4: two loads in one frame, last one wins.
    push_frame(16'h2222, 4'b0000);
    step(5);
    load(16'h1111, 4'b0000);
    step(9);
    load(16'h2222, 4'b0000);
    check("busy_overwrite", Busy, 1'b1);
    wait_ft(n);
    check("busy_clear_overwrite", Busy, 1'b0);

    // F5: decimal point only on digit 2 in F6.
    push_frame(16'h5678, 4'b0100);
    step(3);
    load(16'h5678, 4'b0100);
    wait_ft(n);

    // F6: leading-zero blanking of 0050 in F7.
    BlankLeadZero = 1'b1;
    push_run(4'b1110, 4'h0, 1'b0, 6);
    push_run(4'b1101, 4'h5, 1'b0, 6);
    step(3);
    load(16'h0050, 4'b0000);
    wait_ft(n);

    // F7: value 0 shows a single 0; digit 3 stays dark despite its point request.
    push_run(4'b1110, 4'h0, 1'b0, 6);
    step(3);
    load(16'h0000, 4'b1000);
    wait_ft(n);

    // F8: queue 4321 for F9, plus everything the rest of the run displays.
    push_run(4'b1110, 4'h1, 1'b0, 2);
    push_frame(16'h9876, 4'b0000);
    push_run(4'b1110, 4'h6, 1'b0, 6);
    push_run(4'b1101, 4'h7, 1'b0, 3);
    push_frame(16'h0000, 4'b0000);
    step(3);
    load(16'h4321, 4'b0000);
    wait_ft(n);

    // F9: pending load, then Enable dropped while digit 0 is lit.
    step(2);
    load(16'h9876, 4'b0000);
    check("busy_before_disable", Busy, 1'b1);
    step(1);
    Enable = 1'b0;
    step(1);
    check("an_dark_next_cycle", AN, 4'b1111);
    check("busy_apply_disabled", Busy, 1'b0);
    step(3);
    check("an_dark_held", AN, 4'b1111);
    Enable = 1'b1;
    step(1);
    check("reenable_blank_1", AN, 4'b1111);
    step(1);
    check("reenable_blank_2", AN, 4'b1111);
    step(1);
    check("reenable_first_lit", AN, 4'b1110);
    check("reenable_first_hex", Hex, 4'h6);
    wait_ft(n);
    check("ft_after_reenable", n, 29);

    // Reset mid-frame with a pending value and a simultaneous load.
    step(10);
    load(16'hABCD, 4'b0000);
    check("busy_before_reset", Busy, 1'b1);
    step(2);
    Rst = 1'b1; Load = 1'b1; Value = 16'h5555; DPMask = 4'b1111; BlankLeadZero = 1'b0;
    step(1);
    check("rst_load_an", AN, 4'b1111);
    check("rst_load_hex", Hex, 4'h0);
    check("rst_load_dp", DP, 1'b0);
    check("rst_load_frame_tick", FrameTick, 1'b0);
    check("rst_load_busy", Busy, 1'b0);
    Rst  = 1'b0;
    Load = 1'b0;
    wait_ft(n);
    check("ft_after_reset", n, 32);
    check("busy_after_reset", Busy, 1'b0);

    step(2);
    Enable = 1'b0;
    step(2);
    check("runs_all_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_controller.md
SSEG_SCAN_CONTROLLER -- requirements
Module: sseg_scan_controller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 64, anode-off cycles at the start of each slot (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Enable  input  1  1 = scan running; 0 = display dark, scan held.
REQ-006 SHALL have port Load  input  1  single-cycle strobe; captures Value and DPMask.
REQ-007 SHALL have port Value  input  16  four hex nibbles; nibble 3 = [15:12] = leftmost digit.
REQ-008 SHALL have port DPMask  input  4  per-digit decimal-point request; bit i belongs to digit i.
REQ-009 SHALL have port BlankLeadZero  input  1  1 = suppress leading zero digits.
REQ-010 SHALL have port Hex  output  4  nibble for the downstream hex-to-7-segment decoder.
REQ-011 SHALL have port DP  output  1  decimal point for the decoder; 1 = point lit.
REQ-012 SHALL have port AN  output  4  digit anode enables, active-low; AN[i] low = digit i on.
REQ-013 SHALL have port FrameTick  output  1  one-cycle pulse at the end of each four-digit frame.
REQ-014 SHALL have port Busy  output  1  1 = a loaded value is pending and not yet displayed.

Function
REQ-015 SHALL keep DivCnt (0..REFRESH_DIV-1) and Digit (0..3); when Enable=1, DivCnt increments each cycle.
REQ-016 SHALL, at DivCnt=REFRESH_DIV-1, set DivCnt to 0 and advance Digit, wrapping from 3 to 0.
REQ-017 SHALL assert FrameTick for exactly one cycle: the cycle after DivCnt=REFRESH_DIV-1 with Digit=3.
REQ-018 SHALL double-buffer the display value: Load writes Value/DPMask into pending registers and sets Busy the next cycle.
REQ-019 SHALL copy pending into the active registers on the frame boundary (DivCnt=REFRESH_DIV-1, Digit=3) and clear Busy in the same update.
REQ-020 SHALL let a Load on the frame-boundary cycle go directly to the active registers; Busy stays 0.
REQ-021 SHALL let a Load while Busy=1 overwrite the pending value (last write wins); Busy stays 1.
REQ-022 SHALL, when Enable=0, copy a Load directly to the active registers with Busy=0.
REQ-023 SHALL apply any already-pending value to the active registers while Enable=0.
REQ-024 SHALL register Hex, DP and AN, so they reflect the previous cycle's Digit/DivCnt/active state (latency 1).
REQ-025 SHALL drive Hex as active nibble[Digit] and DP as active DPMask[Digit].
REQ-026 SHALL drive AN=4'b1111 whenever DivCnt<BLANK_CYC (ghosting guard).
REQ-027 SHALL otherwise drive AN low only on bit Digit, unless that digit is blanked.
REQ-028 SHALL treat digit i (i=1..3) as blanked when BlankLeadZero=1 and active nibbles i..3 are all zero.
REQ-029 SHALL never blank digit 0, so a value of 0 shows a single "0".
REQ-030 SHALL keep a blanked digit dark even when its DPMask bit is 1.
REQ-031 SHALL, when Enable falls to 0, force AN=1111 and reset DivCnt and Digit to 0 on the next cycle, and hold them there.
REQ-032 SHALL restart the scan at Digit 0, DivCnt 0 when Enable returns to 1.
REQ-033 SHALL give Rst priority over Load and Enable in the same cycle.

Reset
REQ-034 SHALL, on Rst=1 at a clock edge, set DivCnt=0, Digit=0, active and pending Value=0, active and pending DPMask=0.
REQ-035 SHALL, on that same reset edge, set AN=4'b1111, Hex=0, DP=0, FrameTick=0 and Busy=0.
REQ-036 SHALL discard a pending load when Rst is asserted mid-frame; the next display after reset shows 0000.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-037 SHALL cover: reset, then Enable=1 and Load Value=16'h12AF, DPMask=0 -> AN sequence 1110,1101,1011,0111, each low 6 of 8 cycles; Hex=F,A,2,1; FrameTick every 32 cycles.
REQ-038 SHALL cover: Load 16'h1234 mid-frame while 16'h12AF is shown -> Busy=1 until the frame boundary; the next frame shows 4,3,2,1 with no mixed frame.
REQ-039 SHALL cover: two Loads in one frame (16'h1111 then 16'h2222) -> only 2222 is ever displayed.
REQ-040 SHALL cover: BlankLeadZero=1 and Value=16'h0050 -> digits 3 and 2 stay AN-high; digits 1 and 0 show 5 and 0. Value=0 -> only digit 0 lit, showing 0.
REQ-041 SHALL cover: DPMask=4'b0100 -> DP=1 only while Digit=2 is driven.
REQ-042 SHALL cover: Enable dropped mid-slot -> AN=1111 the next cycle; on re-enable the first lit digit is 0 after 2 blank cycles. Rst asserted together with Load -> all outputs at reset values and Busy=0.
